// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
// Contents: deframer state encoding, frame geometry, default parameter values,
// and the odd-parity helper used when parity checking is compiled in.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_FILTER_LEN  = 4;
  localparam int DEF_TIMEOUT_CYC = 10000;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - CPU-side read port of the PS/2 keyboard receiver
// Signals: ps2_rd (read strobe, from bus decoder), key_scan (FIFO head byte),
// ps2_ready (FIFO non-empty), overflow (sticky drop flag), frame_err (pulse).
// master = bus decoder side, slave = receiver side.
interface ps2_kbd_rx_if;
  logic       ps2_rd;
  logic [7:0] key_scan;
  logic       ps2_ready;
  logic       overflow;
  logic       frame_err;

  modport master (output ps2_rd, input key_scan, ps2_ready, overflow, frame_err);
  modport slave  (input ps2_rd, output key_scan, ps2_ready, overflow, frame_err);
endinterface

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-FF synchronizer, glitch filter and falling-edge pulse
// Ports: clk, rst (async, active high), raw_i (asynchronous line),
// fall_o (one-cycle pulse when the filtered level goes 1 -> 0).
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level;
  // the level flips only once FILTER_LEN such samples have been seen in a row.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign fall_o = prev_q & ~level_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard deframer with scan-code FIFO
// Ports: clk, rst (async, active high), ps2_clk / ps2_data (raw connector
// lines), bus (ps2_kbd_rx_if.slave: ps2_rd in; key_scan, ps2_ready,
// overflow, frame_err out).
// Build option: PS2_KBD_RX_PARITY_CHECK_EN enables rejection of bad parity.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.slave  bus
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  logic       fall;
  logic [1:0] data_sync_q;
  logic       data_s;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          parity_ok;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          rd_q;
  logic          pop, pop_eff, push_eff, empty, full;
  logic [7:0]    key_scan_q, head_d;
  logic          ready_q, overflow_q, overflow_d;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (ps2_clk),
    .fall_o (fall)
  );

  assign data_s = data_sync_q[1];

`ifdef PS2_KBD_RX_PARITY_CHECK_EN
  assign parity_ok = odd_parity_ok(shift_q, parity_q);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);

    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      shift_d     = '0;
      tmo_d       = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          if (data_s && parity_ok) push_d = 1'b1;
          else                     frame_err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The pushed byte is taken from shift_q, which stays stable in IDLE until
  // the next start bit, far later than the one-cycle push delay.
  always_comb begin
    pop      = bus.ps2_rd & ~rd_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(FIFO_DEPTH));
    pop_eff  = pop & ~empty;
    push_eff = push_q & (~full | pop_eff);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_eff);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_eff);
    // Bypass the write when the new head is the slot being written this cycle.
    head_d = (push_eff && wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]) ? shift_q
                                                                : mem[rd_ptr_d[AW-1:0]];
    overflow_d = overflow_q;
    if (pop_eff)                overflow_d = 1'b0;
    else if (push_q && full)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      data_sync_q <= 2'b11;
      rd_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      key_scan_q  <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      data_sync_q <= {data_sync_q[0], ps2_data};
      rd_q        <= bus.ps2_rd;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      key_scan_q  <= (wr_ptr_d == rd_ptr_d) ? 8'h00 : head_d;
      ready_q     <= (wr_ptr_d != rd_ptr_d);
      overflow_q  <= overflow_d;
    end
  end

  assign bus.key_scan  = key_scan_q;
  assign bus.ps2_ready = ready_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver and scan-code buffer. It is the device-side counterpart of the bus's PS/2 read port at 0xFFFF_Dxxx.
- Samples the external PS/2 clock/data lines and deframes 11-bit frames.
- Queues received bytes in a small FIFO.
- Presents the head byte as key_scan with ps2_ready.
- Pops one byte per CPU read strobe (ps2_rd).

Parameters:
FIFO_DEPTH, 8, number of buffered scan codes; power of two, 2..64
FILTER_LEN, 4, consecutive identical synchronized samples needed to accept a new ps2_clk level
TIMEOUT_CYC, 10000, clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock from connector; asynchronous
ps2_data  in  1  raw PS/2 data from connector; asynchronous
ps2_rd  in  1  read strobe from bus decoder; may stay high for several cycles per CPU access
key_scan  out  8  FIFO head byte; 0x00 when empty
ps2_ready  out  1  FIFO non-empty
overflow  out  1  sticky: a byte was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout

Behaviour:
- Reset (async, rst=1): FSM=IDLE, FIFO empty, key_scan=0, ps2_ready=0, overflow=0, frame_err=0, shift register=0, timeout counter=0, ps2_rd edge register=0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - ps2_clk is then filtered: the filtered level changes only after FILTER_LEN consecutive equal samples. Filter resets to level 1.
  - Falling edge = filtered clk was 1 last cycle and is 0 now; one-cycle pulse `fall`.
  - Data is sampled from the synchronized ps2_data in the `fall` cycle.
- FSM, advancing only on `fall` (except timeout):
  - IDLE: sampled data=0 -> DATA with bit counter=0; data=1 -> stay in IDLE and pulse frame_err.
  - DATA: shift in LSB first, increment counter; after the 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: data=1 and parity OK -> push the byte next cycle, then IDLE. Otherwise pulse frame_err, no push, then IDLE.
- Parity rule: odd parity; the 8 data bits plus the parity bit must contain an odd number of ones.
- Timeout: the counter clears on every `fall` and in IDLE, and increments in any other state. On reaching TIMEOUT_CYC -> IDLE, pulse frame_err, discard the partial byte.
- Pop: pop = ps2_rd & ~ps2_rd_q, i.e. the rising edge of ps2_rd. A strobe held for N cycles pops exactly once. Pop on an empty FIFO is ignored.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; count = wr-rd.
  - Simultaneous push and pop both take effect; count is unchanged. This is legal even when full, because the pop frees the slot first.
  - Push when full without a pop: the new byte is dropped and overflow is set.
  - overflow clears on the next effective pop.
- Outputs are registered from FIFO state. Latency:
  - push in cycle T -> ps2_ready=1 and key_scan valid in T+1;
  - pop in cycle T -> next head or empty state visible in T+1.
- key_scan is forced to 0x00 whenever the FIFO is empty.

Optional Feature:
- Macro PS2_KBD_RX_PARITY_CHECK_EN.
- Defined: behaviour as above; parity failure drops the frame and pulses frame_err.
- Undefined: the parity bit is captured but ignored. Only the start bit, stop bit and timeout can cause frame_err.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3;
  - PS2_FRAME_BITS=11;
  - default parameter constants.
- One sub-module: ps2_sync_filter (2-FF sync + FILTER_LEN glitch filter + `fall` pulse). Instantiate it for ps2_clk; ps2_data uses only its sync stage.
- The FIFO stays inline in ps2_kbd_rx.

Test Plan:
- Good frame: send 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) with a 40 us PS/2 clock at 50 MHz -> ps2_ready=1, key_scan=0x1C one cycle after the push. Then hold ps2_rd high for 5 cycles -> exactly one pop; ps2_ready=0 and key_scan=0x00.
- Burst of 3 bytes: 0xF0, 0x1C, 0x5A -> read back in that order over three ps2_rd pulses; ps2_ready drops only after the third.
- Overflow: send 9 frames, 0x01..0x09, with no reads -> FIFO holds 0x01..0x08, overflow=1. The first pop returns head 0x02 visible and clears overflow.
- Parity error: send 0x1C with parity=1 -> frame_err pulses once and ps2_ready stays 0. With the macro undefined, 0x1C is queued instead.
- Timeout and glitch:
  - Stop the clock after 4 data bits for more than TIMEOUT_CYC -> frame_err pulse and return to IDLE; a following good 0x5A frame is received correctly.
  - A 2-cycle ps2_clk low glitch produces no bit.
- Simultaneous push/pop on a full FIFO in the same cycle -> count stays 8, overflow stays 0. Also assert rst mid-frame -> all outputs return to their reset values immediately.
